// File: rtl/openmips_min_sopc_core.sv
// openmips_min_sopc_core: single-cycle MIPS-subset core, 16-word ROM, LED and
// 4-digit seven-segment output on one board clock.
// Ports:
//   clk_100mhz : board clock, all state on rising edge
//   rst        : asynchronous active-low reset
//   btn[4:0]   : push buttons, readable through $30
//   sw[7:0]    : sw[7] holds CPU in soft reset, sw[6:0] readable through $30
//   seg[7:0]   : active-low segments {dp,g,f,e,d,c,b,a}
//   an[3:0]    : active-low digit enables, an[0] rightmost
//   led[7:0]   : $1[7:0]
module openmips_min_sopc_core #(
    parameter int CPU_DIV   = 1,
    parameter int SCAN_BITS = 16
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    input  logic [4:0] btn,
    input  logic [7:0] sw,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic [7:0] led
);

    localparam int DIV_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] F_ADDU     = 6'h21;
    localparam logic [5:0] F_AND      = 6'h24;
    localparam logic [5:0] F_OR       = 6'h25;

    localparam logic [4:0] IO_REG     = 5'd30;

    function automatic logic [31:0] rom_word(input logic [3:0] idx);
        logic [31:0] w;
        case (idx)
            4'd0:    w = 32'h3401_0000;
            4'd1:    w = 32'h2421_0001;
            4'd2:    w = 32'h0800_0001;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    logic [5:0]           pc;
    logic [5:0]           pc_plus4;
    logic [5:0]           pc_next;
    logic [31:0]          instr;
    logic [31:0]          regs [32];
    logic [DIV_W-1:0]     div_cnt;
    logic                 step_en;
    logic [SCAN_BITS-1:0] scan_cnt;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] io_word;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic [1:0]  digit;
    logic [31:0] r1;
    logic        unused;

    assign instr    = rom_word(pc[5:2]);
    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign imm_zext = {16'h0000, instr[15:0]};
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign unused   = ^instr[10:6];

    assign io_word  = {20'h00000, btn, sw[6:0]};
    assign pc_plus4 = pc + 6'd4;
    assign step_en  = (div_cnt == DIV_W'(CPU_DIV - 1));

    // $0 and $30 are virtual: their array entries are never written.
    always_comb begin
        rs_val = regs[rs];
        if (rs == 5'd0)
            rs_val = '0;
        else if (rs == IO_REG)
            rs_val = io_word;
    end

    always_comb begin
        rt_val = regs[rt];
        if (rt == 5'd0)
            rt_val = '0;
        else if (rt == IO_REG)
            rt_val = io_word;
    end

    // PC is only 6 bits wide, so branch and jump targets wrap modulo 64.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rt;
        wr_data = '0;
        pc_next = pc_plus4;
        case (op)
            OP_SPECIAL: begin
                wr_addr = rd;
                case (funct)
                    F_ADDU: begin
                        wr_en   = 1'b1;
                        wr_data = rs_val + rt_val;
                    end
                    F_OR: begin
                        wr_en   = 1'b1;
                        wr_data = rs_val | rt_val;
                    end
                    F_AND: begin
                        wr_en   = 1'b1;
                        wr_data = rs_val & rt_val;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                wr_en   = 1'b1;
                wr_data = rs_val | imm_zext;
            end
            OP_ADDIU: begin
                wr_en   = 1'b1;
                wr_data = rs_val + imm_sext;
            end
            OP_BEQ: begin
                if (rs_val == rt_val)
                    pc_next = pc_plus4 + {instr[3:0], 2'b00};
            end
            OP_J: begin
                pc_next = {instr[3:0], 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (sw[7] || step_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else if (sw[7]) begin
            pc <= '0;
        end else if (step_en) begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (sw[7]) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (step_en && wr_en &&
                     wr_addr != 5'd0 && wr_addr != IO_REG) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Display scan ignores the soft reset so the panel keeps refreshing.
    always_ff @(posedge clk_100mhz or negedge rst) begin
        if (!rst)
            scan_cnt <= '0;
        else
            scan_cnt <= scan_cnt + 1'b1;
    end

    assign r1    = regs[1];
    assign digit = scan_cnt[SCAN_BITS-1 -: 2];
    assign an    = ~(4'b0001 << digit);
    assign seg   = hex_seg(r1[{digit, 2'b00} +: 4]);
    assign led   = r1[7:0];

endmodule

// File: tb/tb_openmips_min_sopc_core.sv
// Directed bench for openmips_min_sopc_core: reset, run sequence, soft reset,
// I/O register, ALU ops, branches, clock divider and display scan.
module tb_openmips_min_sopc_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn;
    logic [7:0] sw;
    logic [7:0] seg;
    logic [3:0] an;
    logic [7:0] led;

    logic       rst2;
    logic [4:0] btn2;
    logic [7:0] sw2;
    logic [7:0] seg2;
    logic [3:0] an2;
    logic [7:0] led2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] hex_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    always #5 clk = ~clk;

    openmips_min_sopc_core dut (
        .clk_100mhz (clk),
        .rst        (rst_n),
        .btn        (btn),
        .sw         (sw),
        .seg        (seg),
        .an         (an),
        .led        (led)
    );

    openmips_min_sopc_core #(
        .CPU_DIV   (4),
        .SCAN_BITS (4)
    ) u2 (
        .clk_100mhz (clk),
        .rst        (rst2),
        .btn        (btn2),
        .sw         (sw2),
        .seg        (seg2),
        .an         (an2),
        .led        (led2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sw  = (i % 2 == 1) ? 8'h80 : 8'h13;
            btn = 5'(i);
            step();
            n_cmp++;
            if (led !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_led[%0d]: got %h want 00", i, led);
            end
            n_cmp++;
            if (an !== 4'b1110) begin
                n_bad++;
                $display("FAIL reset_an[%0d]: got %b want 1110", i, an);
            end
            n_cmp++;
            if (seg !== 8'hC0) begin
                n_bad++;
                $display("FAIL reset_seg[%0d]: got %h want C0", i, seg);
            end
        end
    endtask

    task automatic run_sequence(input string tag);
        logic [7:0] exp [6] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3};
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (led !== exp[i]) begin
                n_bad++;
                $display("FAIL %s_e%0d: led=%h want %h",
                         tag, i + 1, led, exp[i]);
            end
        end
    endtask

    task automatic test_run();
        btn   = 5'h00;
        sw    = 8'h80;
        rst_n = 1'b1;
        repeat (10) step();
        n_cmp++;
        if (led !== 8'h00) begin
            n_bad++;
            $display("FAIL hold_led: got %h want 00", led);
        end
        sw = 8'h00;
        run_sequence("run");
    endtask

    task automatic test_soft_reset();
        repeat (3) step();
        n_cmp++;
        if (led !== 8'h04) begin
            n_bad++;
            $display("FAIL pre_soft_led: got %h want 04", led);
        end
        sw = 8'h80;
        step();
        n_cmp++;
        if (led !== 8'h00) begin
            n_bad++;
            $display("FAIL soft_led: got %h want 00", led);
        end
        sw = 8'h00;
        run_sequence("resume");
    endtask

    task automatic test_async_reset();
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (led !== 8'h00) begin
            n_bad++;
            $display("FAIL async_led: got %h want 00", led);
        end
        n_cmp++;
        if (an !== 4'b1110 || seg !== 8'hC0) begin
            n_bad++;
            $display("FAIL async_disp: got an=%b seg=%h want 1110/C0",
                     an, seg);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_io_reg();
        sw  = 8'h05;
        btn = 5'h1F;
        force dut.instr = 32'h001E_0825;
        step();
        n_cmp++;
        if (led !== 8'h85) begin
            n_bad++;
            $display("FAIL io_read: led=%h want 85", led);
        end
        force dut.instr = 32'h341E_00FF;
        step();
        force dut.instr = 32'h001E_0825;
        step();
        n_cmp++;
        if (led !== 8'h85) begin
            n_bad++;
            $display("FAIL io_write_ignored: led=%h want 85", led);
        end
        sw  = 8'h7A;
        btn = 5'h00;
        step();
        n_cmp++;
        if (led !== 8'h7A) begin
            n_bad++;
            $display("FAIL io_live: led=%h want 7A", led);
        end
        release dut.instr;
        sw = 8'h00;
    endtask

    task automatic test_alu();
        logic [31:0] prog [9] = '{
            32'h3402_0F0F, 32'h3403_00FF, 32'h0043_0824,
            32'h0043_0821, 32'h0043_0825, 32'hFC01_00AA,
            32'h2401_FFFF, 32'h2421_0001, 32'h3400_0055
        };
        logic [7:0] exp [9] = '{
            8'h00, 8'h00, 8'h0F, 8'h0E, 8'hFF, 8'hFF,
            8'hFF, 8'h00, 8'h00
        };
        sw = 8'h80;
        step();
        sw = 8'h00;
        for (int i = 0; i < 9; i++) begin
            force dut.instr = prog[i];
            step();
            n_cmp++;
            if (led !== exp[i]) begin
                n_bad++;
                $display("FAIL alu_%0d (%h): led=%h want %h",
                         i, prog[i], led, exp[i]);
            end
        end
        force dut.instr = 32'h0000_0825;
        step();
        n_cmp++;
        if (led !== 8'h00) begin
            n_bad++;
            $display("FAIL zero_reg: led=%h want 00", led);
        end
        release dut.instr;
    endtask

    task automatic test_branch();
        logic [31:0] prog [6] = '{
            32'h3404_FFFF, 32'h2405_FFFF, 32'h1085_0003,
            32'h1084_FFFE, 32'h0800_000F, 32'h0000_0000
        };
        logic [5:0] exp [6] = '{
            6'h04, 6'h08, 6'h0C, 6'h08, 6'h3C, 6'h00
        };
        sw = 8'h80;
        step();
        sw = 8'h00;
        for (int i = 0; i < 6; i++) begin
            force dut.instr = prog[i];
            step();
            n_cmp++;
            if (dut.pc !== exp[i]) begin
                n_bad++;
                $display("FAIL branch_%0d (%h): pc=%h want %h",
                         i, prog[i], dut.pc, exp[i]);
            end
        end
        release dut.instr;
    endtask

    task automatic test_div_scan();
        int          k;
        logic [31:0] v;
        logic [1:0]  d;
        logic [3:0]  an_exp;
        logic [7:0]  seg_exp;
        rst2 = 1'b0;
        sw2  = 8'h00;
        btn2 = 5'h00;
        step();
        n_cmp++;
        if (led2 !== 8'h00 || an2 !== 4'b1110 || seg2 !== 8'hC0) begin
            n_bad++;
            $display("FAIL div_reset: led=%h an=%b seg=%h want 00/1110/C0",
                     led2, an2, seg2);
        end
        rst2 = 1'b1;
        k = 0;
        while (k < 37312) begin
            step();
            k++;
            v = 32'(k / 8);
            if (k <= 40) begin
                n_cmp++;
                if (led2 !== v[7:0]) begin
                    n_bad++;
                    $display("FAIL div_led k=%0d: got %h want %h",
                             k, led2, v[7:0]);
                end
            end
            if (k >= 37280) begin
                d       = 2'((k % 16) / 4);
                an_exp  = ~(4'b0001 << d);
                seg_exp = hex_tab[v[{d, 2'b00} +: 4]];
                n_cmp++;
                if (an2 !== an_exp) begin
                    n_bad++;
                    $display("FAIL scan_an k=%0d: got %b want %b",
                             k, an2, an_exp);
                end
                n_cmp++;
                if (seg2 !== seg_exp) begin
                    n_bad++;
                    $display("FAIL scan_seg k=%0d: got %h want %h",
                             k, seg2, seg_exp);
                end
                n_cmp++;
                if (led2 !== v[7:0]) begin
                    n_bad++;
                    $display("FAIL scan_led k=%0d: got %h want %h",
                             k, led2, v[7:0]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = 8'h80;
        btn   = 5'h00;
        rst2  = 1'b0;
        sw2   = 8'h00;
        btn2  = 5'h00;
        test_reset();
        test_run();
        test_soft_reset();
        test_async_reset();
        test_io_reg();
        test_alu();
        test_branch();
        test_div_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
